// File: rtl/plab3_mem_assoc_tag_unit_pkg.sv
// Shared definitions for the associative tag unit: FSM encodings and
// width helpers used by the top level and the PLRU tree.
package plab3_mem_assoc_tag_unit_pkg;

  // Controller-facing FSM encodings
  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_resp = 2'd1;
  localparam logic [1:0] st_fill = 2'd2;

  // Width of a way index; a direct-mapped cache still carries a 1-bit way
  function automatic int way_bits(input int nways);
    return (nways > 1) ? $clog2(nways) : 1;
  endfunction

  // PLRU bits per set (nways-1 tree nodes); one dummy bit when nways=1
  function automatic int plru_bits(input int nways);
    return (nways > 1) ? nways - 1 : 1;
  endfunction

endpackage

// File: rtl/plab3_mem_assoc_tag_unit_plru_tree.sv
// Tree pseudo-LRU for one set. Nodes are heap-ordered: node n has children
// 2n+1 (lower half) and 2n+2 (upper half). A node bit of 0 sends the victim
// search to the lower half. Touching a way makes every node on its path point
// away from it. Purely combinational.
module plab3_mem_plru_tree
  import plab3_mem_assoc_tag_unit_pkg::*;
#(
  parameter int p_nways = 2
) (
  input  logic [plru_bits(p_nways)-1:0] plru,
  input  logic [way_bits(p_nways)-1:0]  touch_way,
  output logic [way_bits(p_nways)-1:0]  victim,
  output logic [plru_bits(p_nways)-1:0] plru_next
);

  localparam int levels = $clog2(p_nways);

  // Walk from the root following the node bits to find the victim
  always_comb begin
    int node;
    // NOTE: every combinationally assigned variable gets a default first so
    // no path through the block leaves it unassigned (no inferred latch).
    victim = '0;
    node   = 0;
    for (int lvl = 0; lvl < levels; lvl++) begin
      victim[levels-1-lvl] = plru[node];
      node = 2 * node + 1 + int'(plru[node]);
    end
  end

  // Walk the touched way's path, pointing each node at the other half
  always_comb begin
    int node;
    plru_next = plru;
    node      = 0;
    for (int lvl = 0; lvl < levels; lvl++) begin
      plru_next[node] = ~touch_way[levels-1-lvl];
      node = 2 * node + 1 + int'(touch_way[levels-1-lvl]);
    end
  end

endmodule

// File: rtl/plab3_mem_assoc_tag_unit.sv
// N-way set-associative tag store for a blocking cache. The controller
// presents a line address, receives hit/way/victim information, and confirms
// the refill of a missed line. Tracks valid/dirty per way and tree PLRU per
// set; reports a dirty victim for writeback; supports bulk invalidate.
module plab3_mem_assoc_tag_unit
  import plab3_mem_assoc_tag_unit_pkg::*;
#(
  parameter int p_nways     = 2,
  parameter int p_nsets     = 8,
  parameter int p_abw       = 32,
  parameter int p_clw       = 128,
  parameter int p_idx_shamt = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_val,
  output logic                          req_rdy,
  input  logic [p_abw-1:0]              req_addr,
  input  logic                          req_write,
  input  logic                          inv_all,
  output logic                          resp_val,
  input  logic                          resp_rdy,
  output logic                          resp_hit,
  output logic [way_bits(p_nways)-1:0]  resp_way,
  output logic                          resp_evict,
  output logic [p_abw-1:0]              resp_evict_addr,
  input  logic                          fill_val,
  output logic                          fill_rdy
);

  localparam int ofw  = $clog2(p_clw / 8);
  localparam int idxw = $clog2(p_nsets);
  localparam int tagw = p_abw - ofw;
  localparam int wayw = way_bits(p_nways);
  localparam int pw   = plru_bits(p_nways);

  // Per-set storage
  logic [tagw-1:0]    tag_q   [p_nsets][p_nways];
  logic [p_nways-1:0] valid_q [p_nsets];
  logic [p_nways-1:0] dirty_q [p_nsets];
  logic [pw-1:0]      plru_q  [p_nsets];

  // Latched request and held victim
  logic [1:0]      state_q;
  logic [tagw-1:0] line_q;
  logic            write_q;
  logic [wayw-1:0] victim_q;

  logic [idxw-1:0]    idx;
  logic [p_nways-1:0] match;
  logic               hit;
  logic [wayw-1:0]    hit_way;
  logic [wayw-1:0]    plru_victim;
  logic [wayw-1:0]    victim_d;
  logic [wayw-1:0]    touch_way;
  logic [pw-1:0]      plru_next;

  // The stored tag is the whole line address, so the index is a slice of it
  assign idx = line_q[p_idx_shamt +: idxw];

  // Tag compare across the ways of the selected set
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < p_nways; w++)
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == line_q);
    for (int w = 0; w < p_nways; w++)
      if (match[w]) hit_way = wayw'(w);
  end

  assign hit = |match;

  // Hit touches the hit way; a fill touches the victim held from RESP
  assign touch_way = (state_q == st_fill) ? victim_q : hit_way;

  plab3_mem_plru_tree #(
    .p_nways (p_nways)
  ) u_plru (
    .plru      (plru_q[idx]),
    .touch_way (touch_way),
    .victim    (plru_victim),
    .plru_next (plru_next)
  );

  // Victim: lowest-index invalid way, otherwise the PLRU choice
  always_comb begin
    victim_d = plru_victim;
    for (int w = p_nways - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim_d = wayw'(w);
  end

  // Handshake and response outputs; response fields are zero outside RESP
  always_comb begin
    req_rdy         = (state_q == st_idle) && !inv_all;
    fill_rdy        = (state_q == st_fill);
    resp_val        = (state_q == st_resp);
    resp_hit        = resp_val && hit;
    resp_way        = resp_val ? (hit ? hit_way : victim_d) : '0;
    resp_evict      = resp_val && !hit && valid_q[idx][victim_d] && dirty_q[idx][victim_d];
    resp_evict_addr = resp_evict ? {tag_q[idx][victim_d], {ofw{1'b0}}} : '0;
  end

  // FSM, latched request and per-set valid/dirty/PLRU state
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= st_idle;
      line_q   <= '0;
      write_q  <= 1'b0;
      victim_q <= '0;
      for (int s = 0; s < p_nsets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        st_idle: begin
          if (inv_all) begin
            for (int s = 0; s < p_nsets; s++) begin
              valid_q[s] <= '0;
              dirty_q[s] <= '0;
              plru_q[s]  <= '0;
            end
          end else if (req_val) begin
            line_q  <= req_addr[p_abw-1:ofw];
            write_q <= req_write;
            state_q <= st_resp;
          end
        end
        st_resp: begin
          if (resp_rdy) begin
            if (hit) begin
              plru_q[idx] <= plru_next;
              if (write_q) dirty_q[idx][hit_way] <= 1'b1;
              state_q <= st_idle;
            end else begin
              victim_q <= victim_d;
              state_q  <= st_fill;
            end
          end
        end
        st_fill: begin
          if (fill_val) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= write_q;
            plru_q[idx]            <= plru_next;
            state_q                <= st_idle;
          end
        end
        default: state_q <= st_idle;
      endcase
    end
  end

  // Tag array write on refill
  // NOTE: tags are deliberately not reset; they are only observed through a
  // set valid bit, so a reset port on the array would add cost for nothing.
  always_ff @(posedge clk) begin
    if (state_q == st_fill && fill_val) tag_q[idx][victim_q] <= line_q;
  end

  // At most one valid way may match a given line address
  assert property (@(posedge clk) disable iff (reset)
    (state_q == st_resp) |-> $onehot0(match));

endmodule

// File: tb/tb_plab3_mem_assoc_tag_unit.sv
// Self-checking bench for the 2-way, 8-set tag unit. The reference model
// keeps each set as two ways plus a "least recently used" way number, which
// for two ways is exactly what tree PLRU selects.
module tb_plab3_mem_assoc_tag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val, req_rdy, req_write, inv_all;
  logic [31:0] req_addr;
  logic        resp_val, resp_rdy, resp_hit, resp_evict;
  logic [0:0]  resp_way;
  logic [31:0] resp_evict_addr;
  logic        fill_val, fill_rdy;

  always #5 clk = ~clk;

  plab3_mem_assoc_tag_unit #(
    .p_nways(2), .p_nsets(8), .p_abw(32), .p_clw(128), .p_idx_shamt(0)
  ) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_write(req_write),
    .inv_all(inv_all),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_evict(resp_evict), .resp_evict_addr(resp_evict_addr),
    .fill_val(fill_val), .fill_rdy(fill_rdy)
  );

  // Reference model
  logic [27:0] m_tag   [8][2];
  bit          m_valid [8][2];
  bit          m_dirty [8][2];
  int          m_lru   [8];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = '0;
      end
      m_lru[s] = 0;
    end
  endtask

  task automatic check_resp(input string pfx, input bit e_hit, input int e_way,
                            input bit e_ev, input logic [31:0] e_ea);
    check({pfx, "_val"},   resp_val, 1);
    check({pfx, "_hit"},   resp_hit, e_hit);
    check({pfx, "_way"},   resp_way, e_way);
    check({pfx, "_evict"}, resp_evict, e_ev);
    check({pfx, "_eaddr"}, resp_evict_addr, e_ea);
    check({pfx, "_reqrdy"}, req_rdy, 0);
  endtask

  // One lookup: request, optional stall with ignored stimulus, accept, fill
  task automatic lookup(input logic [31:0] addr, input bit wr, input int stall,
                        input bit do_fill, output bit o_hit, output int o_way,
                        output bit o_ev, output logic [31:0] o_ea);
    int          s;
    logic [27:0] t;
    bit          e_hit, e_ev;
    int          e_way;
    logic [31:0] e_ea;
    s     = int'(addr[6:4]);
    t     = addr[31:4];
    e_hit = 0;
    e_way = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin e_hit = 1; e_way = w; end
    if (!e_hit) begin
      if (!m_valid[s][0])      e_way = 0;
      else if (!m_valid[s][1]) e_way = 1;
      else                     e_way = m_lru[s];
    end
    e_ev = !e_hit && m_valid[s][e_way] && m_dirty[s][e_way];
    e_ea = e_ev ? {m_tag[s][e_way], 4'b0} : 32'h0;

    @(negedge clk);
    check("idle_req_rdy", req_rdy, 1);
    req_addr  = addr;
    req_write = wr;
    req_val   = 1;
    @(negedge clk);
    req_val = 0;
    o_hit = resp_hit;
    o_way = int'(resp_way);
    o_ev  = resp_evict;
    o_ea  = resp_evict_addr;
    check_resp("resp", e_hit, e_way, e_ev, e_ea);

    // Stall: response must hold; fill_val, req_val and inv_all are ignored
    for (int i = 0; i < stall; i++) begin
      fill_val = (i % 2 == 0);
      inv_all  = (i == 1);
      req_val  = 1;
      @(negedge clk);
      check_resp("stall", e_hit, e_way, e_ev, e_ea);
    end
    fill_val = 0;
    inv_all  = 0;
    req_val  = 0;

    resp_rdy = 1;
    @(negedge clk);
    resp_rdy = 0;
    check("after_resp_val", resp_val, 0);
    if (e_hit) begin
      m_lru[s] = 1 - e_way;
      if (wr) m_dirty[s][e_way] = 1;
      check("hit_back_idle", req_rdy, 1);
    end else begin
      check("fill_rdy", fill_rdy, 1);
      if (do_fill) begin
        fill_val = 1;
        @(negedge clk);
        fill_val = 0;
        m_tag[s][e_way]   = t;
        m_valid[s][e_way] = 1;
        m_dirty[s][e_way] = wr;
        m_lru[s]          = 1 - e_way;
        check("fill_done_idle", req_rdy, 1);
        check("fill_done_rdy", fill_rdy, 0);
      end
    end
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    inv_all = 1;
    #1 check("inv_req_rdy", req_rdy, 0);
    @(negedge clk);
    inv_all = 0;
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      m_lru[s] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rst_req_rdy", req_rdy, 1);
    check("rst_resp_val", resp_val, 0);
    check("rst_fill_rdy", fill_rdy, 0);
    reset = 0;
    model_clear();
  endtask

  // Watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit          h, ev;
    int          w;
    logic [31:0] ea;
    reset = 1; req_val = 0; req_write = 0; req_addr = '0;
    inv_all = 0; resp_rdy = 0; fill_val = 0;
    model_clear();
    #12;
    check("reset_req_rdy", req_rdy, 1);
    check("reset_resp_val", resp_val, 0);
    check("reset_resp_hit", resp_hit, 0);
    check("reset_resp_evict", resp_evict, 0);
    check("reset_fill_rdy", fill_rdy, 0);
    do_reset();

    // Cold miss, fill, then hit
    lookup(32'h1000, 0, 0, 1, h, w, ev, ea);
    check("t1_miss", h, 0); check("t1_way", w, 0); check("t1_ev", ev, 0);
    lookup(32'h1000, 0, 0, 1, h, w, ev, ea);
    check("t1_hit", h, 1); check("t1_hit_way", w, 0);

    // Clean PLRU victim
    do_reset();
    lookup(32'h1000, 0, 0, 1, h, w, ev, ea);
    lookup(32'h1080, 0, 0, 1, h, w, ev, ea);
    lookup(32'h1000, 0, 0, 1, h, w, ev, ea);
    lookup(32'h1100, 0, 0, 1, h, w, ev, ea);
    check("t2_hit", h, 0); check("t2_way", w, 1); check("t2_ev", ev, 0);

    // Dirty victim writeback reporting
    do_reset();
    lookup(32'h2000, 1, 0, 1, h, w, ev, ea);
    lookup(32'h2080, 0, 0, 1, h, w, ev, ea);
    lookup(32'h2100, 0, 0, 1, h, w, ev, ea);
    check("t3_way", w, 0); check("t3_ev", ev, 1); check("t3_ea", ea, 32'h2000);

    // Stalled response with ignored fill_val / req_val / inv_all
    lookup(32'h2100, 0, 3, 1, h, w, ev, ea);
    check("t4_hit_after_stall", h, 1);

    // Bulk invalidate
    do_reset();
    lookup(32'h1000, 1, 0, 1, h, w, ev, ea);
    pulse_inv();
    lookup(32'h1000, 0, 0, 1, h, w, ev, ea);
    check("t5_hit", h, 0); check("t5_way", w, 0); check("t5_ev", ev, 0);

    // Asynchronous reset in the middle of FILL
    lookup(32'h3000, 1, 0, 0, h, w, ev, ea);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("t6_req_rdy", req_rdy, 1);
    check("t6_fill_rdy", fill_rdy, 0);
    check("t6_resp_val", resp_val, 0);
    check("t6_resp_way", resp_way, 0);
    check("t6_resp_eaddr", resp_evict_addr, 0);
    @(negedge clk);
    reset = 0;
    model_clear();
    lookup(32'h1000, 0, 0, 1, h, w, ev, ea);
    check("t6_old_miss", h, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        pulse_inv();
      end else begin
        logic [31:0] a;
        a = 32'h4000 + ($urandom_range(0, 5) << 7) + ($urandom_range(0, 7) << 4)
            + $urandom_range(0, 15);
        lookup(a, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
               1, h, w, ev, ea);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
